// File: rtl/ofifo_drain.sv
// Output FIFO drain: one circular buffer per column, popped a full row at a time.
// Latency: a row is poppable the cycle after its last column is written; out/out_vld appear 1 cycle after an accepted pop.
// Backpressure: o_ready drops when any column is full; writes to a full column without a same-cycle pop are dropped and set sticky overflow.
module ofifo_drain #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [psum_bw*col-1:0] in,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_vld,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   overflow
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] cnt_max = depth[aw:0];

    logic [col-1:0] nonempty;
    logic [col-1:0] full;
    logic [col-1:0] drop;
    logic           pop;

    // Flags look only at registered counts, so there is no wr/rd -> flag path.
    assign o_valid = &nonempty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar k = 0; k < col; k++) begin : g_col
        logic [psum_bw-1:0] mem [depth];
        logic [aw-1:0]      wptr;
        logic [aw-1:0]      rptr;
        logic [aw:0]        cnt;
        logic [psum_bw-1:0] head;
        logic               accept;

        assign full[k]     = (cnt == cnt_max);
        assign nonempty[k] = (cnt != '0);
        // A full column still takes a write when the same edge frees its head slot.
        assign accept      = wr[k] & (~full[k] | pop);
        assign drop[k]     = wr[k] & full[k] & ~pop;

        always_ff @(posedge clk) begin
            if (accept) begin
                mem[wptr] <= in[k*psum_bw +: psum_bw];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                head <= '0;
            end else begin
                if (accept) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                    head <= mem[rptr];
                end
                case ({accept, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        assign out[k*psum_bw +: psum_bw] = head;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_vld  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            out_vld <= pop;
            if (|drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofifo_drain.sv
// Directed bench for ofifo_drain: expected rows queued at issue, a monitor checks every out_vld.
module tb_ofifo_drain;

    localparam int col     = 8;
    localparam int psum_bw = 16;
    localparam int depth   = 16;
    localparam int w       = col * psum_bw;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [col-1:0] wr = '0;
    logic [w-1:0]   in = '0;
    logic           rd = 1'b0;
    logic [w-1:0]   out;
    logic           out_vld;
    logic           o_valid;
    logic           o_full;
    logic           o_ready;
    logic           overflow;

    int tests  = 0;
    int failed = 0;
    logic [w-1:0] exp_q [$];

    ofifo_drain #(.col(col), .psum_bw(psum_bw), .depth(depth)) dut (
        .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd),
        .out(out), .out_vld(out_vld), .o_valid(o_valid), .o_full(o_full),
        .o_ready(o_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Column k of a tagged row carries {k, tag}, so column swaps and stale rows are visible.
    function automatic logic [w-1:0] row(input logic [7:0] tag);
        logic [w-1:0] r;
        r = '0;
        for (int k = 0; k < col; k++) r[k*psum_bw +: psum_bw] = {8'(k), tag};
        return r;
    endfunction

    task automatic chk(input string name, input logic [w-1:0] act, input logic [w-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle from a negedge; queue the expected row if this edge should pop.
    task automatic step(input logic [col-1:0] wv, input logic [7:0] tag, input logic r,
                        input logic exp_pop, input logic [7:0] pop_tag);
        wr = wv;
        in = row(tag);
        rd = r;
        if (exp_pop) exp_q.push_back(row(pop_tag));
        @(negedge clk);
        wr = '0;
        rd = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (out_vld === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_pop: got out=%h, expected no out_vld", out);
            end else begin
                logic [w-1:0] e;
                e = exp_q.pop_front();
                if (out !== e) begin
                    failed++;
                    $display("FAIL pop_data: got %h, expected %h", out, e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_o_valid", w'(o_valid), w'(1'b0));
        chk("rst_o_full", w'(o_full), w'(1'b0));
        chk("rst_o_ready", w'(o_ready), w'(1'b1));
        chk("rst_overflow", w'(overflow), w'(1'b0));
        chk("rst_out", out, '0);
        chk("rst_out_vld", w'(out_vld), w'(1'b0));
        reset = 1'b1;

        // Four rows in, four rows out in order.
        for (int r = 0; r < 4; r++) step('1, 8'(r), 1'b0, 1'b0, 8'h0);
        chk("four_rows_valid", w'(o_valid), w'(1'b1));
        for (int r = 0; r < 4; r++) step('0, 8'h0, 1'b1, 1'b1, 8'(r));
        chk("drained_valid", w'(o_valid), w'(1'b0));
        step('0, 8'h0, 1'b0, 1'b0, 8'h0);
        chk("out_hold", out, row(8'd3));

        // rd on empty is ignored; wr+rd on an empty column does not pop.
        step('0, 8'h0, 1'b1, 1'b0, 8'h0);
        chk("rd_empty_out", out, row(8'd3));
        step('1, 8'h0A, 1'b1, 1'b0, 8'h0);
        chk("wr_rd_empty_valid", w'(o_valid), w'(1'b1));
        step('0, 8'h0, 1'b1, 1'b1, 8'h0A);

        // Skewed columns: column 0 first, the rest five cycles later.
        step(8'h01, 8'h14, 1'b0, 1'b0, 8'h0);
        for (int c = 1; c < 5; c++) begin
            chk("skew_not_valid", w'(o_valid), w'(1'b0));
            step('0, 8'h0, 1'b0, 1'b0, 8'h0);
        end
        chk("skew_not_valid_c5", w'(o_valid), w'(1'b0));
        step(8'hFE, 8'h14, 1'b0, 1'b0, 8'h0);
        chk("skew_valid_c6", w'(o_valid), w'(1'b1));
        step('0, 8'h0, 1'b1, 1'b1, 8'h14);

        // Fill, overflow on a 17th row, drain only the first 16.
        for (int r = 0; r < depth; r++) step('1, 8'(8'h30 + r), 1'b0, 1'b0, 8'h0);
        chk("full_o_full", w'(o_full), w'(1'b1));
        chk("full_o_ready", w'(o_ready), w'(1'b0));
        chk("full_no_overflow", w'(overflow), w'(1'b0));
        step('1, 8'h99, 1'b0, 1'b0, 8'h0);
        chk("drop_overflow", w'(overflow), w'(1'b1));
        chk("drop_still_full", w'(o_full), w'(1'b1));
        for (int r = 0; r < depth; r++) step('0, 8'h0, 1'b1, 1'b1, 8'(8'h30 + r));
        chk("after_drop_empty", w'(o_valid), w'(1'b0));
        chk("overflow_sticky", w'(overflow), w'(1'b1));

        // Reset clears overflow; write+pop on full keeps it full without overflow.
        reset = 1'b0;
        @(negedge clk);
        chk("reset_clears_overflow", w'(overflow), w'(1'b0));
        reset = 1'b1;
        for (int r = 0; r < depth; r++) step('1, 8'(8'h40 + r), 1'b0, 1'b0, 8'h0);
        step('1, 8'h50, 1'b1, 1'b1, 8'h40);
        chk("full_wr_rd_full", w'(o_full), w'(1'b1));
        chk("full_wr_rd_no_overflow", w'(overflow), w'(1'b0));
        for (int r = 1; r <= depth; r++) step('0, 8'h0, 1'b1, 1'b1, 8'(8'h40 + r));
        chk("full_wr_rd_drained", w'(o_valid), w'(1'b0));

        // 48 back-to-back write+pop pairs wrap the pointers three times.
        step('1, 8'd0, 1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 3 * depth; i++) step('1, 8'(i + 1), 1'b1, 1'b1, 8'(i));
        step('0, 8'h0, 1'b1, 1'b1, 8'(3 * depth));
        chk("wrap_drained", w'(o_valid), w'(1'b0));

        // Asynchronous reset mid-cycle with five rows buffered.
        for (int r = 0; r < 5; r++) step('1, 8'(8'h60 + r), 1'b0, 1'b0, 8'h0);
        wr = '1;
        in = row(8'h70);
        rd = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", w'(o_valid), w'(1'b0));
        chk("async_rst_out", out, '0);
        @(negedge clk);
        wr = '0;
        rd = 1'b0;
        reset = 1'b1;
        step('0, 8'h0, 1'b1, 1'b0, 8'h0);
        chk("post_rst_rd_ignored", w'(o_valid), w'(1'b0));
        chk("post_rst_out", out, '0);
        step('1, 8'h77, 1'b0, 1'b0, 8'h0);
        step('0, 8'h0, 1'b1, 1'b1, 8'h77);
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", w'(exp_q.size()), w'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
